// File: rtl/cc_speedgen_pkg.sv
// rtl/cc_speedgen_pkg.sv - shared state encoding, default divisors and width helper for cc_speedgen
package cc_speedgen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SLOW = 2'd1,
    ST_FAST = 2'd2
  } state_e;

  localparam int SLOW_DIV_DEF     = 25_000_000;
  localparam int FAST_DIV_DEF     = 12_500_000;
  localparam int HITS_TO_FAST_DEF = 8;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int cc_width(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/cc_speedgen_if.sv
// rtl/cc_speedgen_if.sv - game-control pulses in, movement ticks and velocity-mux select out
interface cc_speedgen_if;

  logic CC_SPEEDGEN_start_InHigh;
  logic CC_SPEEDGEN_halt_InHigh;
  logic CC_SPEEDGEN_hit_InHigh;
  logic CC_SPEEDGEN_tickSlow_Out;
  logic CC_SPEEDGEN_tickFast_Out;
  logic CC_SPEEDGEN_select_InLow;

  modport master (
    output CC_SPEEDGEN_start_InHigh,
    output CC_SPEEDGEN_halt_InHigh,
    output CC_SPEEDGEN_hit_InHigh,
    input  CC_SPEEDGEN_tickSlow_Out,
    input  CC_SPEEDGEN_tickFast_Out,
    input  CC_SPEEDGEN_select_InLow
  );

  modport slave (
    input  CC_SPEEDGEN_start_InHigh,
    input  CC_SPEEDGEN_halt_InHigh,
    input  CC_SPEEDGEN_hit_InHigh,
    output CC_SPEEDGEN_tickSlow_Out,
    output CC_SPEEDGEN_tickFast_Out,
    output CC_SPEEDGEN_select_InLow
  );

endinterface

// File: rtl/cc_speedgen_prescaler.sv
// rtl/cc_speedgen_prescaler.sv - DIV-period counter with sync clear/enable and a registered one-cycle tick
module cc_prescaler
  import cc_speedgen_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int W = cc_width(DIV);

  logic [W-1:0] cnt_q, cnt_d;
  logic         tick_q, tick_d;

  // The tick is registered on the edge that brings the count to DIV-1, so it is
  // high exactly while the counter sits at its wrap value.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (cnt_q == W'(DIV - 1)) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + W'(1);
      end
      tick_d = (cnt_q == W'(DIV - 2));
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/cc_speedgen.sv
// rtl/cc_speedgen.sv - level FSM, hit counter and the two movement-tick prescalers
module cc_speedgen
  import cc_speedgen_pkg::*;
#(
  parameter int SLOW_DIV     = SLOW_DIV_DEF,
  parameter int FAST_DIV     = FAST_DIV_DEF,
  parameter int HITS_TO_FAST = HITS_TO_FAST_DEF
) (
  input  logic          CC_SPEEDGEN_CLOCK_50,
  input  logic          CC_SPEEDGEN_RESET_InLow,
  cc_speedgen_if.slave  bus
);

  localparam int HW = cc_width(HITS_TO_FAST + 1);

  state_e        state_q, state_d;
  logic [HW-1:0] hits_q, hits_d;
  logic          select_q, select_d;
  logic          presc_clr, presc_en;
  logic          tick_slow, tick_fast;
  logic          start, halt, hit;

  assign start = bus.CC_SPEEDGEN_start_InHigh;
  assign halt  = bus.CC_SPEEDGEN_halt_InHigh;
  assign hit   = bus.CC_SPEEDGEN_hit_InHigh;

  // Priority halt > start > hit; a start also restarts the current rate's period.
  always_comb begin
    state_d   = state_q;
    hits_d    = hits_q;
    presc_clr = 1'b0;
    presc_en  = 1'b0;
    select_d  = 1'b0;

    if (halt) begin
      state_d = ST_IDLE;
    end else if (start) begin
      state_d = ST_SLOW;
      hits_d  = '0;
    end else if (hit) begin
      case (state_q)
        ST_SLOW: begin
          if (hits_q == HW'(HITS_TO_FAST - 1)) begin
            hits_d  = HW'(HITS_TO_FAST);
            state_d = ST_FAST;
          end else begin
            hits_d = hits_q + HW'(1);
          end
        end
        default: ;
      endcase
    end

    presc_clr = (state_d != state_q) || (start && !halt);
    presc_en  = (state_q != ST_IDLE);
    select_d  = (state_d == ST_FAST);
  end

  always_ff @(posedge CC_SPEEDGEN_CLOCK_50 or negedge CC_SPEEDGEN_RESET_InLow) begin
    if (!CC_SPEEDGEN_RESET_InLow) begin
      state_q  <= ST_IDLE;
      hits_q   <= '0;
      select_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      hits_q   <= hits_d;
      select_q <= select_d;
    end
  end

  cc_prescaler #(.DIV(SLOW_DIV)) u_slow (
    .clk_i   (CC_SPEEDGEN_CLOCK_50),
    .rst_n_i (CC_SPEEDGEN_RESET_InLow),
    .clr_i   (presc_clr),
    .en_i    (presc_en),
    .tick_o  (tick_slow)
  );

  cc_prescaler #(.DIV(FAST_DIV)) u_fast (
    .clk_i   (CC_SPEEDGEN_CLOCK_50),
    .rst_n_i (CC_SPEEDGEN_RESET_InLow),
    .clr_i   (presc_clr),
    .en_i    (presc_en),
    .tick_o  (tick_fast)
  );

  assign bus.CC_SPEEDGEN_tickSlow_Out = tick_slow;
  assign bus.CC_SPEEDGEN_tickFast_Out = tick_fast;
  assign bus.CC_SPEEDGEN_select_InLow = select_q;

endmodule

// File: tb/tb_cc_speedgen.sv
// tb/tb_cc_speedgen.sv - directed vectors for cc_speedgen with SLOW_DIV=10, FAST_DIV=4, HITS_TO_FAST=3
module tb_cc_speedgen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  cc_speedgen_if bus();

  cc_speedgen #(.SLOW_DIV(10), .FAST_DIV(4), .HITS_TO_FAST(3)) dut (
    .CC_SPEEDGEN_CLOCK_50    (clk),
    .CC_SPEEDGEN_RESET_InLow (rst_n),
    .bus                     (bus)
  );

  always #5 clk = ~clk;

  // Cycle k is observed at the falling edge just before rising edge k;
  // inputs set there are sampled by rising edge k.
  typedef struct {
    logic start;
    logic halt;
    logic hit;
    logic exp_slow;
    logic exp_fast;
    logic exp_sel;
  } vec_t;

  vec_t vecs [42];

  task automatic chk(input string name, input int cyc, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input int cyc, input logic es, input logic ef, input logic esel);
    chk({name, "_tickSlow"}, cyc, bus.CC_SPEEDGEN_tickSlow_Out, es);
    chk({name, "_tickFast"}, cyc, bus.CC_SPEEDGEN_tickFast_Out, ef);
    chk({name, "_select"},   cyc, bus.CC_SPEEDGEN_select_InLow, esel);
  endtask

  task automatic step(input logic s, input logic h, input logic t);
    bus.CC_SPEEDGEN_start_InHigh = s;
    bus.CC_SPEEDGEN_halt_InHigh  = h;
    bus.CC_SPEEDGEN_hit_InHigh   = t;
    @(negedge clk);
    bus.CC_SPEEDGEN_start_InHigh = 1'b0;
    bus.CC_SPEEDGEN_halt_InHigh  = 1'b0;
    bus.CC_SPEEDGEN_hit_InHigh   = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 42; k++) begin
      vecs[k].start    = (k == 0) || (k == 21);
      vecs[k].halt     = 1'b0;
      vecs[k].hit      = (k inside {2, 5, 7, 12, 24, 26, 33});
      vecs[k].exp_slow = (k inside {17, 31});
      vecs[k].exp_fast = (k inside {4, 11, 15, 19, 25, 29, 33, 37, 41});
      vecs[k].exp_sel  = (k >= 8 && k <= 21) || (k >= 34);
    end

    bus.CC_SPEEDGEN_start_InHigh = 1'b0;
    bus.CC_SPEEDGEN_halt_InHigh  = 1'b0;
    bus.CC_SPEEDGEN_hit_InHigh   = 1'b0;

    #1;
    chk_out("reset", 0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle: no start, nothing moves.
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      chk_out("idle", k, 1'b0, 1'b0, 1'b0);
    end

    // Plain SLOW run from a start at edge 0.
    step(1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 32; k++) begin
      chk_out("slow_run", k, (k % 10) == 0, (k % 4) == 0, 1'b0);
      @(negedge clk);
    end
    step(1'b0, 1'b1, 1'b0);
    @(negedge clk);

    // Hits into FAST, extra hit, restart from FAST, count-up again.
    for (int k = 0; k < 42; k++) begin
      chk_out("table", k, vecs[k].exp_slow, vecs[k].exp_fast, vecs[k].exp_sel);
      step(vecs[k].start, vecs[k].halt, vecs[k].hit);
    end
    step(1'b0, 1'b1, 1'b0);
    @(negedge clk);

    // Hit coincident with start is discarded.
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    chk_out("start_hit", 4, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("start_hit_select", 5, bus.CC_SPEEDGEN_select_InLow, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    chk("start_hit_select", 6, bus.CC_SPEEDGEN_select_InLow, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    @(negedge clk);

    // Halt at edge 6 kills the pending ticks.
    step(1'b1, 1'b0, 1'b0);
    for (int k = 1; k < 6; k++) begin
      if (k == 4) chk("halt_pre_tickFast", k, bus.CC_SPEEDGEN_tickFast_Out, 1'b1);
      step(1'b0, 1'b0, 1'b0);
    end
    step(1'b0, 1'b1, 1'b0);
    for (int k = 7; k <= 12; k++) begin
      chk_out("halt", k, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
    end

    // Halt and start together from SLOW: halt wins.
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    for (int k = 3; k < 15; k++) begin
      chk_out("halt_start", k, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
    end

    // Asynchronous reset in FAST while a tick is high.
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    for (int k = 4; k < 7; k++) step(1'b0, 1'b0, 1'b0);
    chk_out("pre_reset", 7, 1'b0, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("async_reset", 7, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk_out("post_reset", k, 1'b0, 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
